// File: rtl/kv_pkg.sv
// Shared types for the line-fetch arbiter: FSM state encoding and line container.
package kv_pkg;

    localparam int KV_LINE_SIZE  = 4;
    localparam int KV_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } kv_arb_state_t;

    typedef logic [KV_LINE_SIZE-1:0][KV_DATA_WIDTH-1:0] kv_line_t;

endpackage

// File: rtl/kv_rr_arbiter.sv
// Round-robin grant selector; the pointer advances past the winner only when
// enabled and a grant is actually issued.
module kv_rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [REQ_NUM-1:0] i_req,
    input  logic               i_en,
    output logic [REQ_NUM-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_gnt_valid
);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_NUM-1:0] req_hi_s;
    logic [IDX_W-1:0]   idx_hi_s, idx_all_s;

    // Search requesters at/above the pointer first, then wrap to the lowest index.
    always_comb begin
        req_hi_s  = '0;
        idx_hi_s  = '0;
        idx_all_s = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            req_hi_s[i] = i_req[i] && (IDX_W'(i) >= ptr_q);
        end
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx_hi_s  = req_hi_s[i] ? IDX_W'(i) : idx_hi_s;
            idx_all_s = i_req[i]    ? IDX_W'(i) : idx_all_s;
        end
        o_gnt_valid = i_en && (|i_req);
        o_gnt_idx   = (|req_hi_s) ? idx_hi_s : idx_all_s;
        o_gnt       = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            o_gnt[i] = o_gnt_valid && (o_gnt_idx == IDX_W'(i));
        end
        if (o_gnt_valid) begin
            ptr_d = (o_gnt_idx == IDX_W'(REQ_NUM - 1)) ? '0 : (o_gnt_idx + IDX_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/kv_line_fetch_arbiter.sv
// Shares one line-granular memory read port between REQ_NUM cache fill requesters,
// one transaction outstanding, returned line routed back to the granted requester.
module kv_line_fetch_arbiter
    import kv_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_SIZE      = 4,
    parameter int REQ_NUM        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                            i_clk,
    input  logic                                            i_rstn,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]              i_req_addr,
    input  logic [REQ_NUM-1:0]                              i_req_valid,
    output logic [REQ_NUM-1:0]                              o_req_ready,
    output logic [REQ_NUM-1:0][LINE_SIZE-1:0][DATA_WIDTH-1:0] o_rsp_data,
    output logic [REQ_NUM-1:0]                              o_rsp_valid,
    input  logic [REQ_NUM-1:0]                              i_rsp_ready,
    output logic [ADDR_WIDTH-1:0]                           o_mem_addr,
    output logic                                            o_mem_valid,
    input  logic                                            i_mem_ready,
    input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]            i_mem_data,
    input  logic                                            i_mem_valid,
    output logic                                            o_mem_ready,
    output logic                                            o_busy,
    output logic                                            o_timeout
);

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    kv_arb_state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
    logic [IDX_W-1:0]                      owner_q, owner_d;
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  line_q, line_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  timeout_q, timeout_d;

    logic               arb_en_s;
    logic [REQ_NUM-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic               gnt_valid_s;

    assign arb_en_s = (state_q == IDLE);

    kv_rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req       (i_req_valid),
        .i_en        (arb_en_s),
        .o_gnt       (gnt_s),
        .o_gnt_idx   (gnt_idx_s),
        .o_gnt_valid (gnt_valid_s)
    );

    // Transaction FSM: grant -> present to memory -> await line -> hand back.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        owner_d   = owner_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    addr_d  = i_req_addr[gnt_idx_s];
                    owner_d = gnt_idx_s;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (i_mem_valid) begin
                    line_d  = i_mem_data;
                    state_d = RESP;
                end else begin
                    // Saturating count; the flag is sticky and never releases the wait.
                    cnt_d = (cnt_q != CNT_MAX) ? (cnt_q + CNT_W'(1)) : cnt_q;
                    if (cnt_d == CNT_MAX) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q;
                    end
                end
            end
            RESP: begin
                if (i_rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            owner_q   <= '0;
            line_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            owner_q   <= owner_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_req_ready = gnt_s;
    assign o_mem_addr  = addr_q;
    assign o_mem_valid = (state_q == REQ);
    assign o_mem_ready = (state_q == WAIT);
    assign o_busy      = (state_q != IDLE);
    assign o_timeout   = timeout_q;
    assign o_rsp_data  = {REQ_NUM{line_q}};

    // Response valid is steered to the owner only.
    always_comb begin
        o_rsp_valid = '0;
        if (state_q == RESP) begin
            o_rsp_valid[owner_q] = 1'b1;
        end else begin
            o_rsp_valid = '0;
        end
    end

endmodule

// File: tb/tb_kv_line_fetch_arbiter.sv
// Randomized and directed bench for kv_line_fetch_arbiter against a transaction-level model.
module tb_kv_line_fetch_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LS  = 4;
    localparam int RN  = 2;
    localparam int TMO = 8;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_RESP = 3;

    logic                          i_clk;
    logic                          i_rstn;
    logic [RN-1:0][AW-1:0]         i_req_addr;
    logic [RN-1:0]                 i_req_valid;
    logic [RN-1:0]                 o_req_ready;
    logic [RN-1:0][LS-1:0][DW-1:0] o_rsp_data;
    logic [RN-1:0]                 o_rsp_valid;
    logic [RN-1:0]                 i_rsp_ready;
    logic [AW-1:0]                 o_mem_addr;
    logic                          o_mem_valid;
    logic                          i_mem_ready;
    logic [LS-1:0][DW-1:0]         i_mem_data;
    logic                          i_mem_valid;
    logic                          o_mem_ready;
    logic                          o_busy;
    logic                          o_timeout;

    kv_line_fetch_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_SIZE(LS), .REQ_NUM(RN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_mem_addr(o_mem_addr), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: which phase the single outstanding fetch is in.
    int                    m_ph, m_ptr, m_owner, m_wait;
    bit                    m_to;
    logic [AW-1:0]         m_addr;
    logic [LS-1:0][DW-1:0] m_line;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int pick();
        for (int k = 0; k < RN; k++) begin
            int c;
            c = (m_ptr + k) % RN;
            if (i_req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_ptr = 0; m_owner = 0; m_wait = 0; m_to = 1'b0;
        m_addr = '0; m_line = '0;
    endtask

    task automatic model_step();
        int g;
        if (!i_rstn) begin
            model_reset();
        end else begin
            case (m_ph)
                P_IDLE: begin
                    g = pick();
                    if (g >= 0) begin
                        m_addr = i_req_addr[g]; m_owner = g; m_ptr = (g + 1) % RN; m_ph = P_REQ;
                    end
                end
                P_REQ:  if (i_mem_ready) begin m_ph = P_WAIT; m_wait = 0; end
                P_WAIT: begin
                    if (i_mem_valid) begin
                        m_line = i_mem_data; m_ph = P_RESP;
                    end else begin
                        m_wait++;
                        if (m_wait >= TMO) m_to = 1'b1;
                    end
                end
                P_RESP: if (i_rsp_ready[m_owner]) m_ph = P_IDLE;
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            logic [RN-1:0] exp_rdy, exp_rv;
            int g;
            g = pick();
            exp_rdy = (m_ph == P_IDLE && g >= 0) ? (RN'(1) << g) : '0;
            exp_rv  = (m_ph == P_RESP) ? (RN'(1) << m_owner) : '0;
            chk("req_ready", 128'(o_req_ready), 128'(exp_rdy));
            chk("rsp_valid", 128'(o_rsp_valid), 128'(exp_rv));
            chk("mem_valid", 128'(o_mem_valid), 128'(m_ph == P_REQ));
            chk("mem_ready", 128'(o_mem_ready), 128'(m_ph == P_WAIT));
            chk("busy",      128'(o_busy),      128'(m_ph != P_IDLE));
            chk("timeout",   128'(o_timeout),   128'(m_to));
            chk("mem_addr",  128'(o_mem_addr),  128'(m_addr));
            for (int r = 0; r < RN; r++) chk("rsp_data", 128'(o_rsp_data[r]), 128'(m_line));
        end
    end

    task automatic set_idle_inputs();
        i_req_valid = '0; i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_rsp_ready = '1;
    endtask

    task automatic rand_line(output logic [LS-1:0][DW-1:0] l);
        for (int w = 0; w < LS; w++) l[w] = $urandom;
    endtask

    task automatic do_reset();
        #1;
        i_rstn = 1'b0;
        model_reset();
        step();
        step();
        i_rstn = 1'b1;
    endtask

    initial begin
        logic [LS-1:0][DW-1:0] lit, ld;
        int gq[$];
        logic [AW-1:0] aq[$];

        i_rstn = 1'b0;
        i_req_addr = '0;
        i_mem_data = '0;
        set_idle_inputs();
        model_reset();
        step();
        chk_en = 1'b1;
        step();
        chk("rst_mem_valid", 128'(o_mem_valid), 128'(0));
        chk("rst_mem_ready", 128'(o_mem_ready), 128'(0));
        chk("rst_busy",      128'(o_busy),      128'(0));
        chk("rst_timeout",   128'(o_timeout),   128'(0));
        chk("rst_rsp_valid", 128'(o_rsp_valid), 128'(0));
        chk("rst_mem_addr",  128'(o_mem_addr),  128'(0));
        chk("rst_rsp_data",  128'(o_rsp_data),  128'(0));
        i_rstn = 1'b1;

        // Contention: both requesters held valid.
        i_req_valid = 2'b11; i_req_addr[0] = 32'h100; i_req_addr[1] = 32'h200;
        i_mem_ready = 1'b1; i_mem_valid = 1'b1; rand_line(i_mem_data);
        for (int c = 0; c < 16; c++) begin
            #1;
            for (int r = 0; r < RN; r++) if (o_req_ready[r]) gq.push_back(r);
            if (o_mem_valid && i_mem_ready) aq.push_back(o_mem_addr);
            step();
        end
        set_idle_inputs();
        chk("fair_count", 128'(gq.size()), 128'(4));
        chk("fair_addrs", 128'(aq.size()), 128'(4));
        for (int k = 0; k < 4 && k < gq.size() && k < aq.size(); k++) begin
            chk("fair_order", 128'(gq[k]), 128'(k % 2));
            chk("fair_addr",  128'(aq[k]), 128'((k % 2 == 0) ? 32'h100 : 32'h200));
        end

        // Single request from requester 0.
        i_req_valid = 2'b01; i_req_addr[0] = 32'h1000; i_mem_ready = 1'b1;
        step();
        chk("single_addr",  128'(o_mem_addr),  128'(32'h1000));
        chk("single_mval",  128'(o_mem_valid), 128'(1));
        i_req_valid = '0;
        step();
        step();
        lit[0] = 32'd1; lit[1] = 32'd2; lit[2] = 32'd3; lit[3] = 32'd4;
        i_mem_valid = 1'b1; i_mem_data = lit;
        step();
        chk("single_rv",    128'(o_rsp_valid),   128'(2'b01));
        chk("single_data0", 128'(o_rsp_data[0]), 128'(lit));
        chk("single_data1", 128'(o_rsp_data[1]), 128'(lit));
        i_mem_valid = 1'b0;
        step();
        chk("single_done",  128'(o_busy), 128'(0));

        // Backpressure on memory request and on requester 1's response.
        i_req_valid = 2'b10; i_req_addr[1] = 32'h300; i_mem_ready = 1'b0;
        step();
        i_req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_mval", 128'(o_mem_valid), 128'(1));
            chk("bp_addr", 128'(o_mem_addr),  128'(32'h300));
            step();
        end
        i_mem_ready = 1'b1;
        step();
        rand_line(ld);
        i_mem_valid = 1'b1; i_mem_data = ld; i_rsp_ready = 2'b01; i_req_valid = 2'b01;
        step();
        i_mem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rv",   128'(o_rsp_valid),   128'(2'b10));
            chk("bp_data", 128'(o_rsp_data[1]), 128'(ld));
            chk("bp_nogr", 128'(o_req_ready),   128'(0));
            step();
        end
        set_idle_inputs();
        step();
        chk("bp_done", 128'(o_busy), 128'(0));

        // Spurious memory valid in IDLE and REQ.
        i_mem_valid = 1'b1; rand_line(i_mem_data);
        step();
        chk("spur_idle_rv", 128'(o_rsp_valid), 128'(0));
        chk("spur_idle_bz", 128'(o_busy),      128'(0));
        i_req_valid = 2'b01; i_req_addr[0] = 32'h400;
        step();
        i_req_valid = '0;
        step();
        chk("spur_req_mv", 128'(o_mem_valid), 128'(1));
        chk("spur_req_rv", 128'(o_rsp_valid), 128'(0));
        i_mem_ready = 1'b1; i_mem_valid = 1'b0;
        step();
        i_mem_valid = 1'b1;
        step();
        set_idle_inputs();
        step();

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 2000; c++) begin
            i_req_valid = RN'($urandom_range(0, 3));
            for (int r = 0; r < RN; r++) i_req_addr[r] = $urandom;
            i_mem_ready = ($urandom_range(0, 3) != 0);
            i_mem_valid = ($urandom_range(0, 2) == 0);
            rand_line(i_mem_data);
            i_rsp_ready = RN'($urandom_range(0, 3));
            step();
        end
        set_idle_inputs();
        do_reset();

        // Timeout after TMO WAIT cycles, then late completion.
        i_req_valid = 2'b01; i_req_addr[0] = 32'h500; i_mem_ready = 1'b1;
        step();
        i_req_valid = '0;
        step();
        for (int k = 0; k < TMO; k++) begin
            chk("to_early", 128'(o_timeout), 128'(0));
            step();
        end
        chk("to_set", 128'(o_timeout), 128'(1));
        step();
        step();
        rand_line(ld);
        i_mem_valid = 1'b1; i_mem_data = ld;
        step();
        chk("to_rv",     128'(o_rsp_valid),   128'(2'b01));
        chk("to_data",   128'(o_rsp_data[0]), 128'(ld));
        chk("to_sticky", 128'(o_timeout),     128'(1));
        i_mem_valid = 1'b0;
        step();
        chk("to_after",  128'(o_timeout), 128'(1));

        // Reset asserted in WAIT.
        i_req_valid = 2'b10; i_req_addr[1] = 32'h600;
        step();
        i_req_valid = '0;
        step();
        step();
        #1;
        i_rstn = 1'b0;
        model_reset();
        #1;
        chk("arst_mval", 128'(o_mem_valid), 128'(0));
        chk("arst_mrdy", 128'(o_mem_ready), 128'(0));
        chk("arst_busy", 128'(o_busy),      128'(0));
        chk("arst_to",   128'(o_timeout),   128'(0));
        chk("arst_rv",   128'(o_rsp_valid), 128'(0));
        chk("arst_addr", 128'(o_mem_addr),  128'(0));
        step();
        i_req_valid = 2'b11; i_req_addr[0] = 32'h700; i_req_addr[1] = 32'h800;
        i_rstn = 1'b1;
        #1;
        chk("arst_prio", 128'(o_req_ready), 128'(2'b01));
        step();
        chk("arst_addr0", 128'(o_mem_addr), 128'(32'h700));
        i_req_valid = '0; i_mem_ready = 1'b1; i_mem_valid = 1'b1;
        for (int c = 0; c < 4; c++) step();
        set_idle_inputs();
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
